// File: rtl/dmac_pkg.sv
// Shared constants for the N-channel DMA controller: FSM encodings, AHB
// transfer types, CTRL bit positions and the slave register map.
package dmac_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_RA   = 3'd2;
    localparam logic [2:0] ST_RD   = 3'd3;
    localparam logic [2:0] ST_WA   = 3'd4;
    localparam logic [2:0] ST_WD   = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;
    localparam logic [2:0] ST_ERR  = 3'd7;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_SRC_INC = 1;
    localparam int CTRL_DST_INC = 2;
    localparam int CTRL_IRQ_EN  = 3;

    localparam logic [3:0]  OFS_SRC   = 4'h0;
    localparam logic [3:0]  OFS_DST   = 4'h4;
    localparam logic [3:0]  OFS_CNT   = 4'h8;
    localparam logic [3:0]  OFS_CTRL  = 4'hC;
    localparam logic [11:0] ADDR_STAT = 12'h100;

endpackage

// File: rtl/dmac_rr_arbiter.sv
// Round-robin pick among ready channels, searching upward from ptr with wrap.
// Purely combinational; the caller owns the pointer.
module dmac_rr_arbiter #(
    parameter int N_CH = 4,
    parameter int IW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] ready,
    input  logic [IW-1:0]   ptr,
    output logic [N_CH-1:0] grant,
    output logic [IW-1:0]   index
);

    always_comb begin
        int  j;
        logic found;
        grant = '0;
        index = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N_CH; i++) begin
            j = (int'(ptr) + i) % N_CH;
            if (!found && ready[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                index    = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/dmac_nch.sv
// N-channel DMA controller: AHB-lite register slave, round-robin channel
// selection and a word-by-word read/write engine on the AHB-lite master.
//
// state | meaning
// IDLE  | waiting for a ready channel; winner latched on exit
// REQ   | requesting the system bus, waiting for Bus_Grant
// RA    | read address phase at SRC
// RD    | read data phase, holding register loads on MReady
// WA    | write address phase at DST
// WD    | write data phase, channel writeback on MReady
// DONE  | count exhausted: flag, clear EN, pulse ReqAck
// ERR   | bus error: flag, clear EN, no writeback
module dmac_nch
    import dmac_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int AW    = 32,
    parameter int CW    = 16,
    parameter int CHUNK = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            HSel,
    input  logic [11:0]     HAddr,
    input  logic [1:0]      STrans,
    input  logic            write,
    input  logic [31:0]     HWData,
    output logic [31:0]     HRData,
    output logic            HReadyOut,
    input  logic [N_CH-1:0] DmacReq,
    output logic [N_CH-1:0] ReqAck,
    output logic            Bus_Req,
    input  logic            Bus_Grant,
    output logic [AW-1:0]   MAddress,
    output logic [31:0]     MWData,
    input  logic [31:0]     MRData,
    output logic            MWrite,
    output logic [1:0]      MTrans,
    input  logic            MReady,
    input  logic            MResp,
    output logic            Interrupt
);

    localparam int IW = $clog2(N_CH);

    logic [AW-1:0]   src  [N_CH];
    logic [AW-1:0]   dst  [N_CH];
    logic [CW-1:0]   cnt  [N_CH];
    logic [3:0]      ctrl [N_CH];
    logic [N_CH-1:0] done_flag, err_flag, ready, irq_en, grant;
    logic [31:0]     stat_word;

    logic            ap_valid, ap_write, ap_is_ch, ap_is_stat, wr_en;
    logic [11:0]     ap_addr;
    logic [IW-1:0]   ap_ch;
    logic [3:0]      ap_ofs;

    logic [2:0]      state;
    logic [IW-1:0]   ch, rr_ptr, rr_next, win_idx;
    logic [4:0]      beats_left;
    logic [31:0]     hold;
    logic [CW-1:0]   cnt_nxt;
    logic            eng_wb, irq;

    assign ap_ch      = ap_addr[4 +: IW];
    assign ap_ofs     = ap_addr[3:0];
    assign ap_is_ch   = (ap_addr[11:8] == 4'h0) && (ap_addr[7:4] < 4'(N_CH));
    assign ap_is_stat = (ap_addr == ADDR_STAT);
    assign wr_en      = ap_valid && ap_write;

    always_comb begin
        for (int n = 0; n < N_CH; n++) begin
            ready[n]  = ctrl[n][CTRL_EN] & DmacReq[n] & (cnt[n] != '0) & ~err_flag[n];
            irq_en[n] = ctrl[n][CTRL_IRQ_EN];
        end
    end

    always_comb begin
        stat_word              = '0;
        stat_word[N_CH-1:0]    = done_flag;
        stat_word[8 +: N_CH]   = err_flag;
    end

    always_comb begin
        HRData = '0;
        if (ap_valid && !ap_write) begin
            if (ap_is_ch) begin
                case (ap_ofs)
                    OFS_SRC:  HRData = 32'(src[ap_ch]);
                    OFS_DST:  HRData = 32'(dst[ap_ch]);
                    OFS_CNT:  HRData = 32'(cnt[ap_ch]);
                    OFS_CTRL: HRData = 32'(ctrl[ap_ch]);
                    default:  HRData = '0;
                endcase
            end else if (ap_is_stat) begin
                HRData = stat_word;
            end
        end
    end

    dmac_rr_arbiter #(.N_CH(N_CH), .IW(IW)) u_arb (
        .ready (ready),
        .ptr   (rr_ptr),
        .grant (grant),
        .index (win_idx)
    );

    assign cnt_nxt = cnt[ch] - CW'(1);
    assign eng_wb  = (state == ST_WD) && MReady && !MResp;
    assign rr_next = (int'(ch) == N_CH - 1) ? '0 : ch + IW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ch         <= '0;
            rr_ptr     <= '0;
            beats_left <= '0;
            hold       <= '0;
        end else begin
            case (state)
                ST_IDLE: if (|grant) begin
                    ch         <= win_idx;
                    beats_left <= 5'(CHUNK);
                    state      <= ST_REQ;
                end
                ST_REQ: if (Bus_Grant) state <= ST_RA;
                ST_RA:  state <= ST_RD;
                ST_RD: if (MReady) begin
                    if (MResp) state <= ST_ERR;
                    else begin
                        hold  <= MRData;
                        state <= ST_WA;
                    end
                end
                ST_WA:  state <= ST_WD;
                ST_WD: if (MReady) begin
                    if (MResp) state <= ST_ERR;
                    else begin
                        beats_left <= beats_left - 5'd1;
                        if (cnt_nxt == '0) state <= ST_DONE;
                        // tenure ends on chunk limit, request drop or software disable
                        else if (beats_left == 5'd1 || !DmacReq[ch] || !ctrl[ch][CTRL_EN]) begin
                            state  <= ST_IDLE;
                            rr_ptr <= rr_next;
                        end else state <= ST_RA;
                    end
                end
                ST_DONE, ST_ERR: begin
                    state  <= ST_IDLE;
                    rr_ptr <= rr_next;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < N_CH; n++) begin
                src[n]  <= '0;
                dst[n]  <= '0;
                cnt[n]  <= '0;
                ctrl[n] <= '0;
            end
            done_flag <= '0;
            err_flag  <= '0;
            ap_valid  <= 1'b0;
            ap_write  <= 1'b0;
            ap_addr   <= '0;
            irq       <= 1'b0;
        end else begin
            ap_valid <= HSel && (STrans == HT_NONSEQ || STrans == HT_SEQ);
            ap_write <= write;
            ap_addr  <= HAddr;
            if (wr_en && ap_is_ch) begin
                case (ap_ofs)
                    OFS_SRC:  src[ap_ch]  <= AW'(HWData);
                    OFS_DST:  dst[ap_ch]  <= AW'(HWData);
                    OFS_CNT:  cnt[ap_ch]  <= HWData[CW-1:0];
                    OFS_CTRL: ctrl[ap_ch] <= HWData[3:0];
                    default: ;
                endcase
            end
            if (wr_en && ap_is_stat) begin
                done_flag <= done_flag & ~HWData[N_CH-1:0];
                err_flag  <= err_flag & ~HWData[8 +: N_CH];
            end
            // engine writeback is issued last so it overrides a colliding slave write
            if (eng_wb) begin
                src[ch] <= src[ch] + (ctrl[ch][CTRL_SRC_INC] ? AW'(4) : AW'(0));
                dst[ch] <= dst[ch] + (ctrl[ch][CTRL_DST_INC] ? AW'(4) : AW'(0));
                cnt[ch] <= cnt_nxt;
            end
            if (state == ST_DONE) begin
                done_flag[ch]        <= 1'b1;
                ctrl[ch][CTRL_EN]    <= 1'b0;
            end
            if (state == ST_ERR) begin
                err_flag[ch]         <= 1'b1;
                ctrl[ch][CTRL_EN]    <= 1'b0;
            end
            irq <= (|(done_flag & irq_en)) | (|(err_flag & irq_en));
        end
    end

    assign HReadyOut = 1'b1;
    assign Interrupt = irq;
    assign Bus_Req   = (state != ST_IDLE);
    assign MTrans    = (state == ST_RA || state == ST_WA) ? HT_NONSEQ : HT_IDLE;
    assign MWrite    = (state == ST_WA || state == ST_WD);
    assign MAddress  = (state == ST_RA || state == ST_RD) ? src[ch] :
                       (state == ST_WA || state == ST_WD) ? dst[ch] : '0;
    assign MWData    = hold;
    assign ReqAck    = (state == ST_DONE) ? (N_CH'(1) << ch) : '0;

endmodule

// File: tb/tb_dmac_nch.sv
// Directed bench for dmac_nch: register programming over the slave port, a
// small bus responder with wait-state and error injection, and assertions.
module tb_dmac_nch;

    logic        clk, rst;
    logic        HSel, write;
    logic [11:0] HAddr;
    logic [1:0]  STrans;
    logic [31:0] HWData, HRData;
    logic        HReadyOut;
    logic [3:0]  DmacReq, ReqAck;
    logic        Bus_Req, Bus_Grant;
    logic [31:0] MAddress, MWData, MRData;
    logic        MWrite, MReady, MResp, Interrupt;
    logic [1:0]  MTrans;

    dmac_nch #(.N_CH(4), .AW(32), .CW(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .HSel(HSel), .HAddr(HAddr), .STrans(STrans),
        .write(write), .HWData(HWData), .HRData(HRData), .HReadyOut(HReadyOut),
        .DmacReq(DmacReq), .ReqAck(ReqAck), .Bus_Req(Bus_Req), .Bus_Grant(Bus_Grant),
        .MAddress(MAddress), .MWData(MWData), .MRData(MRData), .MWrite(MWrite),
        .MTrans(MTrans), .MReady(MReady), .MResp(MResp), .Interrupt(Interrupt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'hC3A5_0000;
    endfunction

    // bus responder state
    logic        dp_valid, dp_write, stalled_prev, br_prev, snap_write;
    logic [31:0] dp_addr, snap_addr, snap_wdata;
    logic [1:0]  snap_trans;
    int          wait_left, rd_count, stall_cycles, unstable, br_rises;
    int          wait_cfg = 0;
    int          err_rd_idx = -1;
    int          ack_cnt [4];
    logic [31:0] rd_addr_q [$];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];

    assign MReady = !(dp_valid && wait_left != 0);
    assign MRData = pat(dp_addr);
    assign MResp  = dp_valid && !dp_write && (wait_left == 0) && (rd_count == err_rd_idx);

    always @(posedge clk) begin
        if (rst) begin
            dp_valid     <= 1'b0;
            wait_left    <= 0;
            stalled_prev <= 1'b0;
        end else begin
            if (dp_valid && MReady) begin
                dp_valid <= 1'b0;
                if (dp_write) begin
                    wr_addr_q.push_back(dp_addr);
                    wr_data_q.push_back(MWData);
                end else begin
                    rd_addr_q.push_back(dp_addr);
                    rd_count <= rd_count + 1;
                end
            end else if (dp_valid) wait_left <= wait_left - 1;
            if (MTrans == 2'b10) begin
                dp_valid  <= 1'b1;
                dp_write  <= MWrite;
                dp_addr   <= MAddress;
                wait_left <= wait_cfg;
            end
            stalled_prev <= dp_valid && !MReady;
            if (dp_valid && !MReady) begin
                stall_cycles <= stall_cycles + 1;
                if (!stalled_prev) begin
                    snap_addr  <= MAddress;
                    snap_wdata <= MWData;
                    snap_trans <= MTrans;
                    snap_write <= MWrite;
                end else if (MAddress !== snap_addr || MWData !== snap_wdata ||
                             MTrans !== snap_trans || MWrite !== snap_write)
                    unstable <= unstable + 1;
            end
        end
        br_prev <= Bus_Req;
        if (Bus_Req && !br_prev) br_rises <= br_rises + 1;
        for (int i = 0; i < 4; i++) if (ReqAck[i]) ack_cnt[i] <= ack_cnt[i] + 1;
    end

    int          total = 0;
    int          bad = 0;
    int          r0, w0, a0, s0, u0, b0;
    logic [31:0] rdata, ea, ed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic ahb_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        HSel = 1'b1; HAddr = a; STrans = 2'b10; write = 1'b1;
        @(negedge clk);
        HSel = 1'b0; STrans = 2'b00; write = 1'b0; HWData = d;
    endtask

    task automatic ahb_read(input logic [11:0] a, output logic [31:0] d);
        @(negedge clk);
        HSel = 1'b1; HAddr = a; STrans = 2'b10; write = 1'b0;
        @(negedge clk);
        HSel = 1'b0; STrans = 2'b00;
        d = HRData;
    endtask

    task automatic program_ch(input int n, input logic [31:0] s, input logic [31:0] d,
                              input logic [31:0] c, input logic [31:0] ct);
        ahb_write(12'(n * 16 + 0),  s);
        ahb_write(12'(n * 16 + 4),  d);
        ahb_write(12'(n * 16 + 8),  c);
        ahb_write(12'(n * 16 + 12), ct);
    endtask

    initial begin
        rst = 1'b1; HSel = 1'b0; HAddr = '0; STrans = 2'b00; write = 1'b0; HWData = '0;
        DmacReq = '0; Bus_Grant = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hready", 32'(HReadyOut), 32'd1);
        check("rst_busreq", 32'(Bus_Req), 32'd0);
        check("rst_mtrans", 32'(MTrans), 32'd0);
        check("rst_maddr", MAddress, 32'd0);
        check("rst_irq", 32'(Interrupt), 32'd0);
        check("rst_ack", 32'(ReqAck), 32'd0);
        rst = 1'b0;
        ahb_read(12'h100, rdata); check("rst_stat", rdata, 32'd0);
        ahb_read(12'h008, rdata); check("rst_cnt0", rdata, 32'd0);

        // single channel, grant withheld at first
        program_ch(0, 32'h1000, 32'h2000, 32'd3, 32'hF);
        r0 = rd_addr_q.size(); w0 = wr_addr_q.size(); a0 = ack_cnt[0];
        DmacReq = 4'b0001;
        repeat (3) @(negedge clk);
        check("t1_req_wait", 32'(Bus_Req), 32'd1);
        check("t1_req_idle_bus", 32'(MTrans), 32'd0);
        Bus_Grant = 1'b1;
        for (int k = 0; k < 300 && ack_cnt[0] == a0; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("t1_ack", 32'(ack_cnt[0] - a0), 32'd1);
        check("t1_nrd", 32'(rd_addr_q.size() - r0), 32'd3);
        check("t1_nwr", 32'(wr_addr_q.size() - w0), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check("t1_rd_addr", rd_addr_q[r0 + k], 32'h1000 + 32'(4 * k));
            check("t1_wr_addr", wr_addr_q[w0 + k], 32'h2000 + 32'(4 * k));
            check("t1_wr_data", wr_data_q[w0 + k], pat(32'h1000 + 32'(4 * k)));
        end
        check("t1_irq", 32'(Interrupt), 32'd1);
        ahb_read(12'h100, rdata); check("t1_stat", rdata, 32'h1);
        ahb_read(12'h008, rdata); check("t1_cnt", rdata, 32'd0);
        ahb_read(12'h00C, rdata); check("t1_ctrl", rdata, 32'hE);
        ahb_write(12'h100, 32'h1);
        repeat (3) @(negedge clk);
        check("t1_irq_clr", 32'(Interrupt), 32'd0);
        ahb_read(12'h100, rdata); check("t1_stat_clr", rdata, 32'd0);

        // two channels interleaved by chunk
        DmacReq = 4'b0000;
        program_ch(1, 32'h3000, 32'h5000, 32'd8, 32'h7);
        program_ch(2, 32'h4000, 32'h6000, 32'd8, 32'h7);
        r0 = rd_addr_q.size(); w0 = wr_addr_q.size(); b0 = br_rises;
        a0 = ack_cnt[1] + ack_cnt[2];
        DmacReq = 4'b0110;
        for (int k = 0; k < 600 && (ack_cnt[1] + ack_cnt[2]) < a0 + 2; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("t2_acks", 32'(ack_cnt[1] + ack_cnt[2] - a0), 32'd2);
        check("t2_nrd", 32'(rd_addr_q.size() - r0), 32'd16);
        check("t2_tenures", 32'(br_rises - b0), 32'd4);
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 4; k++) begin
                ea = ((t % 2 == 0) ? 32'h3000 : 32'h4000) + 32'((t / 2) * 16 + k * 4);
                ed = ((t % 2 == 0) ? 32'h5000 : 32'h6000) + 32'((t / 2) * 16 + k * 4);
                check("t2_rd_addr", rd_addr_q[r0 + t * 4 + k], ea);
                check("t2_wr_addr", wr_addr_q[w0 + t * 4 + k], ed);
                check("t2_wr_data", wr_data_q[w0 + t * 4 + k], pat(ea));
            end
        end
        check("t2_irq_masked", 32'(Interrupt), 32'd0);

        // fixed destination
        DmacReq = 4'b0000;
        program_ch(3, 32'h7000, 32'h8000, 32'd2, 32'h3);
        w0 = wr_addr_q.size(); a0 = ack_cnt[3];
        DmacReq = 4'b1000;
        for (int k = 0; k < 200 && ack_cnt[3] == a0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("t3_ack", 32'(ack_cnt[3] - a0), 32'd1);
        check("t3_wr_addr0", wr_addr_q[w0], 32'h8000);
        check("t3_wr_addr1", wr_addr_q[w0 + 1], 32'h8000);
        check("t3_wr_data1", wr_data_q[w0 + 1], pat(32'h7004));
        ahb_read(12'h030, rdata); check("t3_src", rdata, 32'h7008);
        ahb_read(12'h034, rdata); check("t3_dst", rdata, 32'h8000);

        // wait states in both data phases
        DmacReq = 4'b0000;
        wait_cfg = 3;
        program_ch(0, 32'h9000, 32'hA000, 32'd1, 32'h7);
        w0 = wr_addr_q.size(); a0 = ack_cnt[0]; s0 = stall_cycles; u0 = unstable;
        DmacReq = 4'b0001;
        for (int k = 0; k < 200 && ack_cnt[0] == a0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        wait_cfg = 0;
        check("t4_ack", 32'(ack_cnt[0] - a0), 32'd1);
        check("t4_stalls", 32'(stall_cycles - s0), 32'd6);
        check("t4_stable", 32'(unstable - u0), 32'd0);
        check("t4_wr_addr", wr_addr_q[w0], 32'hA000);
        check("t4_wr_data", wr_data_q[w0], pat(32'h9000));

        // bus error on the second read
        DmacReq = 4'b0000;
        ahb_write(12'h100, 32'hFFFF);
        program_ch(1, 32'hB000, 32'hC000, 32'd4, 32'hF);
        repeat (2) @(negedge clk);
        check("t5_irq_pre", 32'(Interrupt), 32'd0);
        w0 = wr_addr_q.size(); a0 = ack_cnt[1];
        err_rd_idx = rd_count + 1;
        DmacReq = 4'b0010;
        for (int k = 0; k < 200 && Interrupt == 1'b0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        err_rd_idx = -1;
        check("t5_irq", 32'(Interrupt), 32'd1);
        check("t5_no_ack", 32'(ack_cnt[1] - a0), 32'd0);
        check("t5_nwr", 32'(wr_addr_q.size() - w0), 32'd1);
        ahb_read(12'h100, rdata); check("t5_stat", rdata, 32'h200);
        ahb_read(12'h018, rdata); check("t5_cnt", rdata, 32'd3);
        ahb_read(12'h01C, rdata); check("t5_ctrl", rdata, 32'hE);
        ahb_read(12'h010, rdata); check("t5_src", rdata, 32'hB004);

        // reset during a stalled write data phase
        DmacReq = 4'b0000;
        program_ch(2, 32'hD000, 32'hE000, 32'd5, 32'hF);
        wait_cfg = 3;
        DmacReq = 4'b0100;
        for (int k = 0; k < 200 && !(dp_valid && dp_write && !MReady); k++) @(negedge clk);
        check("t6_in_wd", 32'(MWrite && Bus_Req), 32'd1);
        check("t6_irq_pre", 32'(Interrupt), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_mtrans", 32'(MTrans), 32'd0);
        check("t6_busreq", 32'(Bus_Req), 32'd0);
        check("t6_irq", 32'(Interrupt), 32'd0);
        rst = 1'b0;
        wait_cfg = 0;
        r0 = rd_addr_q.size();
        ahb_read(12'h028, rdata); check("t6_cnt", rdata, 32'd0);
        ahb_read(12'h02C, rdata); check("t6_ctrl", rdata, 32'd0);
        ahb_read(12'h100, rdata); check("t6_stat", rdata, 32'd0);
        repeat (20) @(negedge clk);
        check("t6_quiet_req", 32'(Bus_Req), 32'd0);
        check("t6_quiet_rd", 32'(rd_addr_q.size() - r0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmac_nch.md
Name: dmac_nch

Overview:
- N-channel successor to the two-channel DMA controller.
- Channel count, address width and chunk length are parameters; the two-channel design has fixed values.
- A round-robin arbiter selects among ready channels. The selected channel moves up to CHUNK words, then the bus is released and arbitration runs again.
- Software programs per-channel registers through an AHB-lite slave port. Data moves word by word over an AHB-lite master port via a holding register. Each channel has a done flag, an error flag and a maskable interrupt.

Parameters:
- N_CH, 4, number of channels (2..8)
- AW, 32, master address width
- CW, 16, transfer-count width (words)
- CHUNK, 4, max words per bus tenure before re-arbitration (1..16)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- HSel  in  1  slave select
- HAddr  in  12  slave address (byte)
- STrans  in  2  slave HTRANS
- write  in  1  slave HWRITE
- HWData  in  32  slave write data
- HRData  out  32  slave read data
- HReadyOut  out  1  slave ready (always 1)
- DmacReq  in  N_CH  peripheral requests, level
- ReqAck  out  N_CH  one-cycle pulse at channel completion
- Bus_Req  out  1  request to the system arbiter
- Bus_Grant  in  1  grant from the system arbiter
- MAddress  out  AW  master address
- MWData  out  32  master write data
- MRData  in  32  master read data
- MWrite  out  1  master HWRITE
- MTrans  out  2  master HTRANS (IDLE=00, NONSEQ=10)
- MReady  in  1  master HREADY
- MResp  in  1  master HRESP (1 = ERROR)
- Interrupt  out  1  OR of enabled done/error flags

Behaviour:
- Reset values:
  - All registers 0, FSM in IDLE, rr pointer 0.
  - All outputs 0, except HReadyOut = 1.
- Register map, channel n at base n*0x10:
  - 0x0 SRC (AW bits)
  - 0x4 DST (AW bits)
  - 0x8 CNT (CW bits)
  - 0xC CTRL: b0 EN, b1 SRC_INC, b2 DST_INC, b3 IRQ_EN
- Global register 0x100 STAT, read / write-1-to-clear:
  - [N_CH-1:0] DONE
  - [N_CH+7:8] ERR
- Unmapped addresses read 0; writes to them are ignored.
- Slave writes:
  - Address and write are captured when HSel & STrans[1].
  - The register updates from HWData in the next (data-phase) cycle.
- Slave reads return the register value in the data phase.
- Engine writeback has priority over a same-cycle slave write to SRC, DST or CNT of the active channel. The slave write is dropped.
- Channel ready = EN & DmacReq[n] & (CNT != 0) & !ERR[n].
- Arbitration is round-robin:
  - Search starts at rr pointer; the first ready channel wins.
  - rr pointer becomes winner+1 (mod N_CH) when the tenure ends.
- FSM states:
  - IDLE: if any channel is ready, latch the winner → REQ.
  - REQ: Bus_Req=1; on Bus_Grant → RA.
  - RA: MTrans=NONSEQ, MWrite=0, MAddress=SRC → RD.
  - RD: MTrans=IDLE. When MReady, capture MRData into the holding register → WA; if MResp → ERR.
  - WA: MTrans=NONSEQ, MWrite=1, MAddress=DST → WD.
  - WD: MWData=holding register. When MReady:
    - SRC += 4 if SRC_INC; DST += 4 if DST_INC; CNT -= 1; beat counter += 1.
    - If CNT becomes 0 → DONE.
    - Else if beat counter == CHUNK, or DmacReq[ch] is low → IDLE (Bus_Req drops).
    - Else → RA.
    - If MResp → ERR.
  - DONE: set DONE[ch], clear EN, ReqAck[ch]=1 for exactly one cycle → IDLE.
  - ERR: set ERR[ch], clear EN, no ReqAck, no register writeback for the failed beat → IDLE.
- Bus_Req is held from REQ through WD and deasserts in the cycle the FSM enters IDLE.
- Losing Bus_Grant mid-tenure is not supported: the system arbiter must hold the grant while Bus_Req=1.
- Wait states: the FSM holds RD or WD with all master outputs stable until MReady.
- Address arithmetic wraps modulo 2^AW.
- CNT written as 0 with EN=1: the channel is never ready; EN stays 1.
- Software clearing EN mid-tenure: the current beat completes, then the FSM → IDLE without setting DONE.
- Interrupt = |(DONE & IRQ_EN) | |(ERR & IRQ_EN), registered (one-cycle latency).
- Reset mid-transfer:
  - The next cycle has MTrans=IDLE and Bus_Req=0.
  - All channel state is cleared.

Decomposition:
- Package dmac_pkg holds:
  - State enum
  - HTRANS constants
  - CTRL bit indices
  - Register offsets (SRC/DST/CNT/CTRL/STAT)
- Sub-module dmac_rr_arbiter (N_CH): ready vector + pointer in, one-hot grant + index out. Purely combinational.
- Top level holds:
  - Register file
  - Transfer FSM
  - Slave decode

Test Plan:
- Single channel, ch0 SRC=0x1000, DST=0x2000, CNT=3, EN|SRC_INC|DST_INC|IRQ_EN, DmacReq[0] held, MReady=1 → reads at 0x1000/4/8 and writes at 0x2000/4/8 with matching data, one ReqAck[0] pulse, DONE[0]=1, Interrupt=1; writing 0x1 to STAT clears Interrupt.
- ch1 and ch2 both ready with CNT=8, CHUNK=4 → grant order ch1(4 words), ch2(4 words), ch1(4 words), ch2(4 words); Bus_Req drops for at least 1 cycle between tenures.
- Fixed-address mode, DST_INC=0, CNT=2 → both writes go to the same DST; SRC advances by 4.
- MReady low for 3 cycles in RD and in WD → MAddress, MTrans and MWData stable throughout; data still correct.
- MResp=1 on the second read → ERR[n]=1, EN=0, CNT still equals initial-1, no ReqAck, Interrupt=1 if IRQ_EN.
- Assert rst during WD with CNT=5 → next cycle MTrans=00, Bus_Req=0, CNT=0, Interrupt=0; no transfers until reprogrammed.
